mem_arbiter: RTL and testbench

- Shares the single-port 256x8 data memory between two requesters: port 0 (CPU load/store unit) and port 1 (loader/debug DMA).
- Arbitrates with a round-robin pointer or fixed priority, latches the winning request, and sequences exactly one memory access.
- Returns read data with a one-cycle ack pulse.
- Sits between the requesters and the memory; it is the only driver of the memory's we/in/addr.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_pick2.sv | 28 ++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   state_t       : arbiter FSM encoding (value 3 is unused and treated as IDLE)
//   P_CPU / P_DMA : requester indices into gnt and the internal request vector
//   AW_DEF/DW_DEF : default address / data widths (256x8 memory)
package mem_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  localparam int P_CPU = 0;
  localparam int P_DMA = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way winner selection.
//   i_req   [1:0] : request vector, bit n = port n
//   i_ptr         : round-robin pointer, 0 favours port 0 and 1 favours port 1
//   i_fixed       : 1 = port 0 always wins a tie, pointer ignored
//   o_win   [1:0] : one-hot winner, 0 when nobody requests
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_fixed,
  output logic [1:0] o_win
);

  always_comb begin
    o_win = 2'b00;
    case (i_req)
      2'b01:   o_win[P_CPU] = 1'b1;
      2'b10:   o_win[P_DMA] = 1'b1;
      2'b11: begin
        if (i_fixed || !i_ptr) o_win[P_CPU] = 1'b1;
        else                   o_win[P_DMA] = 1'b1;
      end
      default: o_win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between port 0 (CPU LSU) and
// port 1 (loader/debug DMA). One access per grant, three cycles per grant.
//   clk, rst                  : clock, async active-high reset
//   req/we/addr/wdata{0,1}    : requester command, held until ack
//   ack{0,1}                  : one-cycle completion pulse
//   rdata{0,1}                : read data, valid with ack and held afterwards
//   gnt                       : one-hot owner of the current transaction
//   busy                      : high in ACCESS and DONE
//   mem_we/mem_addr/mem_in    : memory command, only this block drives them
//   mem_out                   : memory combinational read data
//
// state  | meaning
// IDLE   | sample requests, latch the winner's command, set gnt
// ACCESS | drive the latched command to memory, capture mem_out
// DONE   | ack high for the winner; clear gnt, hand pointer to other port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  input  logic [DW-1:0] mem_out
);

  localparam logic LP_FIXED = (FIXED_PRIO != 0);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_in_idle;
  logic          w_in_access;
  logic          w_in_done;
  logic [1:0]    w_req;
  logic [1:0]    w_win;
  logic [1:0]    r_gnt;
  logic          r_ptr;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_ack0;
  logic          r_ack1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  assign w_req = {req1, req0};

  rr_pick2 u_pick (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .i_fixed (LP_FIXED),
    .o_win   (w_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // The unused encoding falls through to default and returns to IDLE
  // without latching anything.
  always_comb begin
    w_state_nxt = IDLE;
    w_in_idle   = 1'b0;
    w_in_access = 1'b0;
    w_in_done   = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_idle   = 1'b1;
        w_state_nxt = (|w_win) ? ACCESS : IDLE;
      end
      ACCESS: begin
        w_in_access = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_in_done   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt    <= 2'b00;
      r_ptr    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_in_idle && (|w_win)) begin
        r_gnt   <= w_win;
        r_we    <= w_win[P_DMA] ? we1    : we0;
        r_addr  <= w_win[P_DMA] ? addr1  : addr0;
        r_wdata <= w_win[P_DMA] ? wdata1 : wdata0;
      end
      // mem_out is captured on writes too (old contents); harmless.
      if (w_in_access) begin
        if (r_gnt[P_DMA]) begin
          r_rdata1 <= mem_out;
          r_ack1   <= 1'b1;
        end else begin
          r_rdata0 <= mem_out;
          r_ack0   <= 1'b1;
        end
      end
      if (w_in_done) begin
        r_ack0 <= 1'b0;
        r_ack1 <= 1'b0;
        r_gnt  <= 2'b00;
        r_ptr  <= r_gnt[P_CPU];
      end
    end
  end

  // Decoded from state so an async reset mid-ACCESS drops the write at once.
  assign mem_we   = w_in_access & r_we;
  assign mem_addr = r_addr;
  assign mem_in   = r_wdata;
  assign busy     = w_in_access | w_in_done;
  assign gnt      = r_gnt;
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  logic       clk, rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1, busy, mem_we;
  logic [7:0] rdata0, rdata1, mem_addr, mem_in, mem_out;
  logic [1:0] gnt;

  logic       req0_f, req1_f, ack0_f, ack1_f, busy_f, mem_we_f;
  logic [7:0] rdata0_f, rdata1_f, mem_addr_f, mem_in_f, mem_out_f;
  logic [1:0] gnt_f;

  logic [7:0] mem [256];
  logic       pl_we;
  logic [7:0] pl_addr, pl_data;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  mem_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .gnt(gnt), .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_out(mem_out)
  );

  mem_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0(req0_f), .we0(1'b0), .addr0(8'h33), .wdata0(8'h00), .ack0(ack0_f), .rdata0(rdata0_f),
    .req1(req1_f), .we1(1'b0), .addr1(8'h44), .wdata1(8'h00), .ack1(ack1_f), .rdata1(rdata1_f),
    .gnt(gnt_f), .busy(busy_f), .mem_we(mem_we_f), .mem_addr(mem_addr_f), .mem_in(mem_in_f),
    .mem_out(mem_out_f)
  );

  // Memory model: sync active-low reset tied to ~rst, sync write, comb read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_in;
    end
  end
  assign mem_out   = mem[mem_addr];
  assign mem_out_f = mem_addr_f ^ 8'h5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_we = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output int cycles, output bit got0,
                          output bit got1, output logic [7:0] rd0, output logic [7:0] rd1);
    cycles = 0; got0 = 0; got1 = 0; rd0 = '0; rd1 = '0;
    while (cycles < budget) begin
      step();
      cycles++;
      if (ack0 || ack1) begin
        got0 = ack0; got1 = ack1; rd0 = rdata0; rd1 = rdata1;
        return;
      end
    end
  endtask

  task automatic sb_pop(output exp_t e, output bit ok);
    ok = (q.size() != 0);
    if (ok) e = q.pop_front();
    else begin e.port = -1; e.data = '0; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({ack0, ack1, gnt, busy, mem_we} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctl got=%b exp=000000", {ack0, ack1, gnt, busy, mem_we});
    end
    step(); step();
    n_vec++;
    if ({rdata0, rdata1, mem_addr, mem_in} !== 32'h0) begin
      n_bad++; $display("FAIL reset_data got=%h exp=00000000", {rdata0, rdata1, mem_addr, mem_in});
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    exp_t e; bit ok, g0, g1; int cyc; logic [7:0] r0, r1;
    we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5; req0 = 1'b1;
    q.push_back('{0, 8'h00});
    step();
    n_vec++;
    if ({gnt, mem_we, busy, mem_addr, mem_in} !== {2'b01, 1'b1, 1'b1, 8'h10, 8'hA5}) begin
      n_bad++; $display("FAIL wr_access got gnt=%b we=%b busy=%b addr=%h in=%h exp 01 1 1 10 a5",
                        gnt, mem_we, busy, mem_addr, mem_in);
    end
    step();
    req0 = 1'b0;
    sb_pop(e, ok);
    n_vec++;
    if (!ok || {ack0, ack1, mem_we} !== 3'b100 || rdata0 !== e.data) begin
      n_bad++; $display("FAIL wr_done got ack0=%b ack1=%b we=%b rdata0=%h exp 1 0 0 %h",
                        ack0, ack1, mem_we, rdata0, e.data);
    end
    step();
    n_vec++;
    if ({ack0, gnt, busy, mem_we} !== 5'b0) begin
      n_bad++; $display("FAIL wr_idle got=%b exp=00000", {ack0, gnt, busy, mem_we});
    end
    we0 = 1'b0; req0 = 1'b1;
    q.push_back('{0, 8'hA5});
    wait_ack(5, cyc, g0, g1, r0, r1);
    req0 = 1'b0;
    sb_pop(e, ok);
    n_vec++;
    if (!ok || !g0 || g1 || cyc != 2 || r0 !== e.data) begin
      n_bad++; $display("FAIL rd_back got ack0=%b ack1=%b lat=%0d rdata0=%h exp 1 0 2 %h",
                        g0, g1, cyc, r0, e.data);
    end
    step();
    n_vec++;
    if (ack0 !== 1'b0 || rdata0 !== 8'hA5) begin
      n_bad++; $display("FAIL rd_hold got ack0=%b rdata0=%h exp 0 a5", ack0, rdata0);
    end
  endtask

  task automatic test_simul_read();
    exp_t e; bit ok, g0, g1; int cyc; logic [7:0] r0, r1;
    rst = 1'b1; step(); step(); rst = 1'b0;
    preload(8'h20, 8'h11);
    preload(8'h21, 8'h22);
    we0 = 1'b0; we1 = 1'b0; addr0 = 8'h20; addr1 = 8'h21;
    req0 = 1'b1; req1 = 1'b1;
    q.push_back('{0, 8'h11});
    q.push_back('{1, 8'h22});
    step();
    n_vec++;
    if (gnt !== 2'b01) begin n_bad++; $display("FAIL sim_gnt0 got=%b exp=01", gnt); end
    wait_ack(4, cyc, g0, g1, r0, r1);
    req0 = 1'b0;
    sb_pop(e, ok);
    n_vec++;
    if (!ok || e.port != 0 || !g0 || g1 || r0 !== e.data) begin
      n_bad++; $display("FAIL sim_first got ack0=%b ack1=%b rdata0=%h exp 1 0 %h", g0, g1, r0, e.data);
    end
    step();
    step();
    n_vec++;
    if (gnt !== 2'b10) begin n_bad++; $display("FAIL sim_gnt1 got=%b exp=10", gnt); end
    wait_ack(4, cyc, g0, g1, r0, r1);
    req1 = 1'b0;
    sb_pop(e, ok);
    n_vec++;
    if (!ok || e.port != 1 || g0 || !g1 || r1 !== e.data) begin
      n_bad++; $display("FAIL sim_second got ack0=%b ack1=%b rdata1=%h exp 0 1 %h", g0, g1, r1, e.data);
    end
    step();
  endtask

  task automatic test_rr_alternate();
    exp_t e; bit ok, g0, g1; int cyc; logic [7:0] r0, r1;
    addr0 = 8'h20; addr1 = 8'h21; we0 = 1'b0; we1 = 1'b0;
    for (int i = 0; i < 8; i++) q.push_back('{i % 2, (i % 2 == 0) ? 8'h11 : 8'h22});
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_ack(4, cyc, g0, g1, r0, r1);
      sb_pop(e, ok);
      n_vec++;
      if (!ok || (g0 && g1) || g0 != (e.port == 0) || g1 != (e.port == 1) ||
          (g0 ? r0 : r1) !== e.data) begin
        n_bad++; $display("FAIL rr_order[%0d] got ack0=%b ack1=%b r0=%h r1=%h exp port=%0d data=%h",
                          i, g0, g1, r0, r1, e.port, e.data);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_fixed_prio();
    exp_t e; bit ok; int n0 = 0; int n1 = 0; int cyc = 0;
    for (int i = 0; i < 8; i++) q.push_back('{0, 8'h33 ^ 8'h5A});
    q.push_back('{1, 8'h44 ^ 8'h5A});
    req0_f = 1'b1; req1_f = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (ack1_f) n1++;
      if (ack0_f) begin
        n0++;
        sb_pop(e, ok);
        n_vec++;
        if (!ok || e.port != 0 || rdata0_f !== e.data) begin
          n_bad++; $display("FAIL fp_data got rdata0=%h exp %h", rdata0_f, e.data);
        end
      end
    end
    n_vec++;
    if (n0 != 8 || n1 != 0) begin
      n_bad++; $display("FAIL fp_counts got ack0=%0d ack1=%0d exp 8 0", n0, n1);
    end
    req0_f = 1'b0;
    while (!ack1_f && cyc < 5) begin step(); cyc++; end
    req1_f = 1'b0;
    sb_pop(e, ok);
    n_vec++;
    if (!ok || e.port != 1 || !ack1_f || rdata1_f !== e.data) begin
      n_bad++; $display("FAIL fp_port1 got ack1=%b rdata1=%h exp 1 %h", ack1_f, rdata1_f, e.data);
    end
    step();
  endtask

  task automatic test_addr_change();
    exp_t e; bit ok;
    preload(8'h30, 8'h77);
    preload(8'h31, 8'h88);
    we1 = 1'b0; addr1 = 8'h30; req1 = 1'b1;
    q.push_back('{1, 8'h77});
    step();
    addr1 = 8'h31;
    #1;
    n_vec++;
    if (mem_addr !== 8'h30 || gnt !== 2'b10) begin
      n_bad++; $display("FAIL ac_addr got addr=%h gnt=%b exp 30 10", mem_addr, gnt);
    end
    step();
    req1 = 1'b0;
    sb_pop(e, ok);
    n_vec++;
    if (!ok || !ack1 || ack0 || rdata1 !== e.data) begin
      n_bad++; $display("FAIL ac_data got ack1=%b ack0=%b rdata1=%h exp 1 0 %h", ack1, ack0, rdata1, e.data);
    end
    n_vec++;
    if (rdata0 !== 8'h11) begin
      n_bad++; $display("FAIL ac_other got rdata0=%h exp 11", rdata0);
    end
    step();
  endtask

  task automatic test_reset_mid_write();
    exp_t e; bit ok, g0, g1; int cyc; logic [7:0] r0, r1;
    we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'hFF; req0 = 1'b1;
    step();
    n_vec++;
    if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rm_we_before got=%b exp=1", mem_we); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({mem_we, ack0, ack1, gnt, busy} !== 6'b0) begin
      n_bad++; $display("FAIL rm_async got=%b exp=000000", {mem_we, ack0, ack1, gnt, busy});
    end
    req0 = 1'b0; we0 = 1'b0;
    step(); step();
    rst = 1'b0;
    req0 = 1'b1;
    q.push_back('{0, 8'h00});
    wait_ack(5, cyc, g0, g1, r0, r1);
    req0 = 1'b0;
    sb_pop(e, ok);
    n_vec++;
    if (!ok || !g0 || r0 !== e.data) begin
      n_bad++; $display("FAIL rm_readback got ack0=%b rdata0=%h exp 1 %h", g0, r0, e.data);
    end
    step();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if ({mem_we, busy, ack0, ack1} !== 4'b0) begin
        n_bad++; $display("FAIL idle[%0d] got=%b exp=0000", i, {mem_we, busy, ack0, ack1});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    req0_f = 0; req1_f = 0;
    pl_we = 0; pl_addr = 0; pl_data = 0;
    test_reset();
    test_write_read();
    test_simul_read();
    test_rr_alternate();
    test_fixed_prio();
    test_addr_change();
    test_reset_mid_write();
    test_idle();
    n_vec++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL sb_leftover got=%0d exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
